// File: rtl/frame_scheduler.sv
// Per-frame admission controller: decides at each vsync rise whether the coming frame
// reaches the MJPG encoder, then gates pvalid/vsync for that whole frame.
module frame_scheduler #(
    parameter int LVL_W   = 12,
    parameter int FIFO_HI = 3072,
    parameter int DIV_W   = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_pvalid,
    input  logic             i_vsync,
    input  logic             i_enable,
    input  logic [DIV_W-1:0] i_div_sel,
    input  logic             i_enc_busy,
    input  logic [LVL_W-1:0] i_fifo_level,
    output logic             o_pvalid,
    output logic             o_vsync,
    output logic             o_frame_start,
    output logic             o_frame_drop,
    output logic [CNT_W-1:0] o_frames_sent,
    output logic [CNT_W-1:0] o_frames_dropped
);

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        PASS      = 2'd1,
        SKIP      = 2'd2
    } state_t;

    localparam logic [LVL_W:0] FIFO_HI_W = FIFO_HI[LVL_W:0];

    state_t             r_state;
    logic [DIV_W-1:0]   r_phase;
    logic               r_vsync_d;
    logic               r_primed;

    logic               w_rise;
    logic               w_phase_zero;
    logic               w_pass_ok;
    logic               w_gate;
    logic               w_drop;
    logic [DIV_W-1:0]   w_phase_next;

    // r_primed masks the first sample after reset: vsync already high at release is
    // mid-frame, not a rising edge.
    always_comb begin
        w_rise       = i_vsync & ~r_vsync_d & r_primed;
        w_phase_zero = (r_phase == '0);
        w_pass_ok    = i_enable & w_phase_zero & ~i_enc_busy &
                       ({1'b0, i_fifo_level} < FIFO_HI_W);
        w_gate       = w_rise ? w_pass_ok : (r_state == PASS);
        w_drop       = w_rise & ~w_pass_ok & i_enable & w_phase_zero;
        w_phase_next = (r_phase >= i_div_sel) ? '0 : r_phase + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= WAIT_SYNC;
            r_phase          <= '0;
            r_vsync_d        <= 1'b0;
            r_primed         <= 1'b0;
            o_pvalid         <= 1'b0;
            o_vsync          <= 1'b0;
            o_frame_start    <= 1'b0;
            o_frame_drop     <= 1'b0;
            o_frames_sent    <= '0;
            o_frames_dropped <= '0;
        end else begin
            r_vsync_d     <= i_vsync;
            r_primed      <= 1'b1;
            o_vsync       <= i_vsync & w_gate;
            o_pvalid      <= i_pvalid & w_gate;
            o_frame_start <= w_rise & w_pass_ok;
            o_frame_drop  <= w_drop;

            if (w_rise) begin
                r_state <= w_pass_ok ? PASS : SKIP;
                r_phase <= w_phase_next;
            end

            // Statistics saturate at all-ones.
            if (w_rise && w_pass_ok && (o_frames_sent != '1))
                o_frames_sent <= o_frames_sent + 1'b1;
            if (w_drop && (o_frames_dropped != '1))
                o_frames_dropped <= o_frames_dropped + 1'b1;
        end
    end

endmodule

// File: tb/tb_frame_scheduler.sv
// Bench for frame_scheduler: directed vector table, hand-written corner sequences and a
// randomized run against a frame-level reference model.
module tb_frame_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pv = 1'b0, vs = 1'b0, en = 1'b0, busy = 1'b0;
    logic [3:0]  div = 4'd0;
    logic [11:0] lvl = 12'd0;

    logic        o_pvalid, o_vsync, o_frame_start, o_frame_drop;
    logic [15:0] o_frames_sent, o_frames_dropped;
    logic        s_pvalid, s_vsync, s_frame_start, s_frame_drop;
    logic [2:0]  s_frames_sent, s_frames_dropped;

    always #5 clk = ~clk;

    frame_scheduler #(.LVL_W(12), .FIFO_HI(3072), .DIV_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .i_pvalid(pv), .i_vsync(vs), .i_enable(en),
        .i_div_sel(div), .i_enc_busy(busy), .i_fifo_level(lvl),
        .o_pvalid(o_pvalid), .o_vsync(o_vsync), .o_frame_start(o_frame_start),
        .o_frame_drop(o_frame_drop), .o_frames_sent(o_frames_sent),
        .o_frames_dropped(o_frames_dropped)
    );

    // Narrow-counter copy on the same stimulus so saturation is reached quickly.
    frame_scheduler #(.LVL_W(12), .FIFO_HI(3072), .DIV_W(4), .CNT_W(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .i_pvalid(pv), .i_vsync(vs), .i_enable(en),
        .i_div_sel(div), .i_enc_busy(busy), .i_fifo_level(lvl),
        .o_pvalid(s_pvalid), .o_vsync(s_vsync), .o_frame_start(s_frame_start),
        .o_frame_drop(s_frame_drop), .o_frames_sent(s_frames_sent),
        .o_frames_dropped(s_frames_dropped)
    );

    int n_vec = 0;
    int n_err = 0;
    int fs_seen = 0;
    int fd_seen = 0;

    // Reference model: frame-level bookkeeping
    bit m_primed, m_prev_vs, m_admit;
    int m_phase, m_sent, m_drop, m_sent_s, m_drop_s;

    typedef struct {
        logic pv, vs, en;
        logic [3:0] div;
        logic busy;
        logic [11:0] lvl;
        logic e_vs, e_pv, e_fs, e_fd;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(bit a_pv, bit a_vs, bit a_en, bit [3:0] a_div, bit a_busy,
                                bit [11:0] a_lvl, bit evs, bit epv, bit efs, bit efd);
        vec_t v;
        v.pv = a_pv; v.vs = a_vs; v.en = a_en; v.div = a_div; v.busy = a_busy; v.lvl = a_lvl;
        v.e_vs = evs; v.e_pv = epv; v.e_fs = efs; v.e_fd = efd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_primed = 0; m_prev_vs = 0; m_admit = 0; m_phase = 0;
        m_sent = 0; m_drop = 0; m_sent_s = 0; m_drop_s = 0;
    endtask

    // Predict one clock from the current inputs, advance, then compare every output.
    task automatic step();
        bit rise, ok, gate, e_vs, e_pv, e_fs, e_fd;
        rise = m_primed && vs && !m_prev_vs;
        ok   = en && (m_phase == 0) && !busy && (int'(lvl) < 3072);
        gate = rise ? ok : m_admit;
        e_vs = vs && gate;
        e_pv = pv && gate;
        e_fs = rise && ok;
        e_fd = rise && !ok && en && (m_phase == 0);
        if (rise) begin
            m_admit = ok;
            m_phase = (m_phase >= int'(div)) ? 0 : m_phase + 1;
        end
        if (e_fs) begin
            if (m_sent < 65535) m_sent++;
            if (m_sent_s < 7) m_sent_s++;
        end
        if (e_fd) begin
            if (m_drop < 65535) m_drop++;
            if (m_drop_s < 7) m_drop_s++;
        end
        m_prev_vs = vs;
        m_primed = 1;
        @(posedge clk);
        #1;
        chk("vsync_out", o_vsync, e_vs);
        chk("pvalid_out", o_pvalid, e_pv);
        chk("frame_start", o_frame_start, e_fs);
        chk("frame_drop", o_frame_drop, e_fd);
        chk("frames_sent", o_frames_sent, m_sent);
        chk("frames_dropped", o_frames_dropped, m_drop);
        chk("sat_frames_sent", s_frames_sent, m_sent_s);
        chk("sat_frames_dropped", s_frames_dropped, m_drop_s);
        fs_seen += int'(o_frame_start);
        fd_seen += int'(o_frame_drop);
    endtask

    task automatic frame(input int hi, input int lo);
        for (int i = 0; i < hi; i++) begin vs = 1; pv = 1; step(); end
        for (int i = 0; i < lo; i++) begin vs = 0; pv = 0; step(); end
    endtask

    int fs0, fd0;

    initial begin
        tbl[0]  = mk(0,1,1,0,0,   0, 0,0,0,0);
        tbl[1]  = mk(1,1,1,0,0,   0, 0,0,0,0);
        tbl[2]  = mk(0,0,1,0,0,   0, 0,0,0,0);
        tbl[3]  = mk(1,1,1,0,0,   0, 1,1,1,0);
        tbl[4]  = mk(1,1,1,0,0,   0, 1,1,0,0);
        tbl[5]  = mk(1,0,1,0,0,   0, 0,1,0,0);
        tbl[6]  = mk(0,0,1,0,0,   0, 0,0,0,0);
        tbl[7]  = mk(1,1,1,0,0,3072, 0,0,0,1);
        tbl[8]  = mk(1,1,1,0,0,   0, 0,0,0,0);
        tbl[9]  = mk(1,0,1,0,0,   0, 0,0,0,0);
        tbl[10] = mk(1,1,1,0,0,3071, 1,1,1,0);
        tbl[11] = mk(1,0,0,0,0,4095, 0,1,0,0);
        tbl[12] = mk(1,0,0,0,1,4095, 0,1,0,0);
        tbl[13] = mk(1,1,0,0,0,   0, 0,0,0,0);
        tbl[14] = mk(1,1,1,0,0,   0, 0,0,0,0);
        tbl[15] = mk(0,0,1,0,0,   0, 0,0,0,0);
        tbl[16] = mk(1,1,1,0,1,   0, 0,0,0,1);
        tbl[17] = mk(0,0,1,0,0,   0, 0,0,0,0);

        // Reset held with vsync already high
        model_reset();
        vs = 1; en = 1; div = 0; busy = 0; lvl = 0; pv = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_vsync_out", o_vsync, 0);
        chk("reset_pvalid_out", o_pvalid, 0);
        chk("reset_frames_sent", o_frames_sent, 0);
        chk("reset_frames_dropped", o_frames_dropped, 0);
        rst_n = 1;

        for (int i = 0; i < 18; i++) begin
            pv = tbl[i].pv; vs = tbl[i].vs; en = tbl[i].en; div = tbl[i].div;
            busy = tbl[i].busy; lvl = tbl[i].lvl;
            step();
            chk($sformatf("tbl%0d_vsync_out", i), o_vsync, tbl[i].e_vs);
            chk($sformatf("tbl%0d_pvalid_out", i), o_pvalid, tbl[i].e_pv);
            chk($sformatf("tbl%0d_frame_start", i), o_frame_start, tbl[i].e_fs);
            chk($sformatf("tbl%0d_frame_drop", i), o_frame_drop, tbl[i].e_fd);
        end
        chk("tbl_frames_sent", o_frames_sent, 2);
        chk("tbl_frames_dropped", o_frames_dropped, 2);

        // Divider 2 over 9 clean frames: frames 0, 3, 6 admitted
        div = 2; en = 1; busy = 0; lvl = 100;
        fs0 = fs_seen; fd0 = fd_seen;
        for (int f = 0; f < 9; f++) frame(3, 2);
        chk("div2_admitted", fs_seen - fs0, 3);
        chk("div2_drops", fd_seen - fd0, 0);
        chk("div2_frames_sent", o_frames_sent, 5);

        // Divider 3 to reach phase 3, then shrink to 1: phase wraps, next frame admitted
        div = 3;
        fs0 = fs_seen;
        for (int f = 0; f < 3; f++) frame(3, 2);
        chk("div3_admitted", fs_seen - fs0, 1);
        div = 1;
        fs0 = fs_seen; fd0 = fd_seen;
        frame(3, 2);
        chk("wrap_frame_admitted", fs_seen - fs0, 0);
        chk("wrap_frame_drop", fd_seen - fd0, 0);
        fs0 = fs_seen;
        frame(3, 2);
        chk("post_wrap_admitted", fs_seen - fs0, 1);

        // Async reset in the middle of an admitted frame
        div = 0;
        frame(3, 2);
        vs = 1; pv = 1; step();
        chk("pre_reset_frame_start", o_frame_start, 1);
        step();
        chk("pre_reset_pvalid", o_pvalid, 1);
        #2 rst_n = 0;
        #1;
        chk("async_vsync_out", o_vsync, 0);
        chk("async_pvalid_out", o_pvalid, 0);
        chk("async_frame_start", o_frame_start, 0);
        chk("async_frames_sent", o_frames_sent, 0);
        chk("async_sat_sent", s_frames_sent, 0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1;
        for (int i = 0; i < 3; i++) step();
        chk("post_reset_no_gate", o_vsync, 0);
        vs = 0; pv = 0; step();
        vs = 1; pv = 1; step();
        chk("post_reset_frame_start", o_frame_start, 1);

        // Randomized run against the model
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 3) == 0) vs = ~vs;
            pv   = 1'($urandom);
            en   = ($urandom_range(0, 9) != 0);
            busy = ($urandom_range(0, 7) == 0);
            lvl  = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(3000, 3100))
                                               : 12'($urandom_range(0, 4095));
            if ($urandom_range(0, 49) == 0) div = 4'($urandom_range(0, 5));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
